// File: rtl/prm_obs_sweep_ctrl.sv
// Obstacle sweep initiator: feeds voxel codes to the edge-checker bank and ORs the returned masks into a readable bitmap.
// Optional PRM_SWEEP_CNT_EN adds accepted-code and blocked-edge counters.
module prm_obs_sweep_ctrl #(
  parameter int unsigned CODE_W    = 15,
  parameter int unsigned NUM_EDGES = 1024,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CHK_LAT   = 1,
  localparam int unsigned NUM_WORDS = NUM_EDGES / WORD_W,
  localparam int unsigned ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned CNT_W     = $clog2(NUM_EDGES) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 code_valid,
  output logic                 code_ready,
  input  logic [CODE_W-1:0]    code_data,
  input  logic                 code_last,
  output logic [CODE_W-1:0]    chk_code,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic                 busy,
  output logic                 done,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [WORD_W-1:0]    rd_data
`ifdef PRM_SWEEP_CNT_EN
  ,
  output logic [15:0]          code_cnt,
  output logic [CNT_W-1:0]     blk_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                           state_q, state_d;
  logic [CHK_LAT-1:0]               vld_q, vld_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0] bmp_q, bmp_d;
  logic [CODE_W-1:0]                chk_code_q, chk_code_d;
  logic [WORD_W-1:0]                rd_data_q, rd_data_d;
  logic                             code_ready_q, code_ready_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             accept;
  logic                             start_acc;

  assign accept    = code_valid & code_ready_q;
  assign start_acc = start & (state_q == S_IDLE);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    vld_d      = CHK_LAT'({vld_q, accept});
    bmp_d      = bmp_q;
    chk_code_d = chk_code_q;
    rd_data_d  = bmp_q[rd_addr];

    // A token leaving the pipeline means chk_mask now reflects that token's code.
    if (vld_q[CHK_LAT-1]) begin
      bmp_d = bmp_q | chk_mask;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = S_SWEEP;
          bmp_d   = '0;
        end
      end
      S_SWEEP: begin
        if (accept) begin
          chk_code_d = code_data;
          if (code_last) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (vld_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    code_ready_d = (state_d == S_SWEEP);
    busy_d       = (state_d == S_SWEEP) || (state_d == S_DRAIN);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vld_q        <= '0;
      bmp_q        <= '0;
      chk_code_q   <= '0;
      rd_data_q    <= '0;
      code_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      bmp_q        <= bmp_d;
      chk_code_q   <= chk_code_d;
      rd_data_q    <= rd_data_d;
      code_ready_q <= code_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign code_ready = code_ready_q;
  assign chk_code   = chk_code_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_data    = rd_data_q;

`ifdef PRM_SWEEP_CNT_EN
  logic [15:0]      code_cnt_q, code_cnt_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  // Saturating accept counter; popcount trails the bitmap by one cycle.
  always_comb begin
    code_cnt_d = code_cnt_q;
    if (start_acc) begin
      code_cnt_d = '0;
    end else if (accept && (code_cnt_q != 16'hFFFF)) begin
      code_cnt_d = code_cnt_q + 16'd1;
    end
    blk_cnt_d = CNT_W'($countones(bmp_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_cnt_q <= '0;
      blk_cnt_q  <= '0;
    end else begin
      code_cnt_q <= code_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  assign code_cnt = code_cnt_q;
  assign blk_cnt  = blk_cnt_q;
`endif

endmodule

// File: tb/tb_prm_obs_sweep_ctrl.sv
// Scoreboard bench for prm_obs_sweep_ctrl: two instances (CHK_LAT=1 and 3) share stimulus;
// the checker bank is modelled as a code->mask table behind a CHK_LAT-1 deep code delay.
module tb_prm_obs_sweep_ctrl;

  typedef struct {
    int          acc;
    logic [14:0] code;
    int          ncode;
    int          nblk;
  } sw_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        code_valid = 1'b0;
  logic        code_last = 1'b0;
  logic [14:0] code_data = '0;
  logic [4:0]  rd_addr = '0;

  logic          ready0, ready1, busy0, busy1, done0, done1;
  logic [14:0]   chk_code0, chk_code1;
  logic [1023:0] mask0, mask1;
  logic [31:0]   rd_data0, rd_data1;
`ifdef PRM_SWEEP_CNT_EN
  logic [15:0]   cc0, cc1;
  logic [10:0]   bc0, bc1;
`endif

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic          rd_req = 1'b0;
  logic          rd_pend = 1'b0;
  sw_t           sw_q0[$], sw_q1[$];
  logic [31:0]   rd_q0[$], rd_q1[$];
  logic [1023:0] tbl [logic [14:0]];
  logic [1023:0] exp_bmp = '0;
  int            n_acc = 0;
  logic [14:0]   last_code = '0;
  logic [14:0]   dly1 [2];
  sw_t           r0, r1;

  prm_obs_sweep_ctrl #(.CHK_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start), .code_valid(code_valid), .code_ready(ready0),
    .code_data(code_data), .code_last(code_last), .chk_code(chk_code0), .chk_mask(mask0),
    .busy(busy0), .done(done0), .rd_addr(rd_addr), .rd_data(rd_data0)
`ifdef PRM_SWEEP_CNT_EN
    , .code_cnt(cc0), .blk_cnt(bc0)
`endif
  );

  prm_obs_sweep_ctrl #(.CHK_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .start(start), .code_valid(code_valid), .code_ready(ready1),
    .code_data(code_data), .code_last(code_last), .chk_code(chk_code1), .chk_mask(mask1),
    .busy(busy1), .done(done1), .rd_addr(rd_addr), .rd_data(rd_data1)
`ifdef PRM_SWEEP_CNT_EN
    , .code_cnt(cc1), .blk_cnt(bc1)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_req;
    dly1[0] <= chk_code1;
    dly1[1] <= dly1[0];
  end

  function automatic logic [1023:0] bitm(input int k);
    logic [1023:0] m;
    m = '0;
    m[10'(k)] = 1'b1;
    return m;
  endfunction

  function automatic logic [1023:0] mask_of(input logic [14:0] c);
    logic [1023:0] m;
    int b;
    if (tbl.exists(c)) return tbl[c];
    b = int'(c);
    m = bitm((b * 37) % 1024);
    if (c[1]) m = m | bitm((b * 101 + 7) % 1024);
    if (c[3:2] == 2'b11) m = m | bitm((b * 13 + 500) % 1024);
    return m;
  endfunction

  // Checker bank: lane 0 combinational, lane 1 retimed by two extra stages.
  always @(negedge clk) begin
    mask0 = mask_of(chk_code0);
    mask1 = mask_of(dly1[1]);
  end

  task automatic check(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lane%0d: got %h expected %h (t=%0t)", nm, lane, act, exp, $time);
    end
  endtask

  task automatic chk_done(input int lane, input int lat, input sw_t r, input logic [14:0] code, input logic bsy);
    check("done_cycle", lane, 32'(cyc), 32'(r.acc + lat + 2));
    check("chk_code_at_done", lane, 32'(code), 32'(r.code));
    check("busy_at_done", lane, 32'(bsy), 32'd0);
  endtask

  // Monitors: pop expectations when the DUT presents done or a read result.
  always @(negedge clk) begin
    if (!rst) begin
      if (done0) begin
        check("done_expected", 0, 32'(sw_q0.size() != 0), 32'd1);
        if (sw_q0.size() != 0) begin
          r0 = sw_q0.pop_front();
          chk_done(0, 1, r0, chk_code0, busy0);
`ifdef PRM_SWEEP_CNT_EN
          check("code_cnt", 0, 32'(cc0), 32'(r0.ncode));
          check("blk_cnt", 0, 32'(bc0), 32'(r0.nblk));
`endif
        end
      end
      if (rd_pend) begin
        check("rd_expected", 0, 32'(rd_q0.size() != 0), 32'd1);
        if (rd_q0.size() != 0) check("rd_data", 0, rd_data0, rd_q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done1) begin
        check("done_expected", 1, 32'(sw_q1.size() != 0), 32'd1);
        if (sw_q1.size() != 0) begin
          r1 = sw_q1.pop_front();
          chk_done(1, 3, r1, chk_code1, busy1);
`ifdef PRM_SWEEP_CNT_EN
          check("code_cnt", 1, 32'(cc1), 32'(r1.ncode));
          check("blk_cnt", 1, 32'(bc1), 32'(r1.nblk));
`endif
        end
      end
      if (rd_pend) begin
        check("rd_expected", 1, 32'(rd_q1.size() != 0), 32'd1);
        if (rd_q1.size() != 0) check("rd_data", 1, rd_data1, rd_q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_bmp = '0;
    n_acc = 0;
    @(negedge clk);
    check("busy_after_start", 0, 32'(busy0), 32'd1);
    check("busy_after_start", 1, 32'(busy1), 32'd1);
    tick();
  endtask

  task automatic send_code(input logic [14:0] c, input logic last);
    logic ok;
    sw_t  r;
    code_valid = 1'b1;
    code_data  = c;
    code_last  = last;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      ok = ready0 && ready1;
    end
    check("accept_seen", 0, 32'(ok), 32'd1);
    if (ok) begin
      exp_bmp = exp_bmp | mask_of(c);
      n_acc++;
      last_code = c;
      if (last) begin
        r.acc   = cyc;
        r.code  = c;
        r.ncode = n_acc;
        r.nblk  = $countones(exp_bmp);
        sw_q0.push_back(r);
        sw_q1.push_back(r);
      end
    end
    tick();
    code_valid = 1'b0;
    code_last  = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sw_q0.size() == 0 && sw_q1.size() == 0) break;
    end
    check("done_pending", 0, 32'(sw_q0.size() + sw_q1.size()), 32'd0);
    sw_q0.delete();
    sw_q1.delete();
    tick();
  endtask

  task automatic read_word(input int a);
    rd_addr = 5'(a);
    rd_req  = 1'b1;
    rd_q0.push_back(exp_bmp[10'(a * 32) +: 32]);
    rd_q1.push_back(exp_bmp[10'(a * 32) +: 32]);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 32; a++) read_word(a);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 0, 32'(ready0), 32'd0);
    check("rst_ready", 1, 32'(ready1), 32'd0);
    check("rst_busy", 0, 32'(busy0), 32'd0);
    check("rst_busy", 1, 32'(busy1), 32'd0);
    check("rst_done", 0, 32'(done0), 32'd0);
    check("rst_done", 1, 32'(done1), 32'd0);
    check("rst_chk_code", 0, 32'(chk_code0), 32'd0);
    check("rst_chk_code", 1, 32'(chk_code1), 32'd0);
    check("rst_rd_data", 0, rd_data0, 32'd0);
    check("rst_rd_data", 1, rd_data1, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Single code sweep: only edge 685 blocked (word 21 bit 13).
    tbl[15'h7FA1] = bitm(685);
    do_start();
    send_code(15'h7FA1, 1'b1);
    wait_done();
    read_all();

    // Back-to-back accepts with distinct masks.
    tbl[15'h0101] = bitm(0);
    tbl[15'h0202] = bitm(0) | bitm(33);
    tbl[15'h0303] = bitm(1023);
    do_start();
    send_code(15'h0101, 1'b0);
    send_code(15'h0202, 1'b0);
    send_code(15'h0303, 1'b1);
    wait_done();
    read_all();

    // Valid held while idle must not be accepted.
    code_valid = 1'b1;
    code_data  = 15'h5555;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready", 0, 32'(ready0), 32'd0);
      check("idle_ready", 1, 32'(ready1), 32'd0);
      tick();
    end
    code_valid = 1'b0;
    @(negedge clk);
    check("idle_chk_code", 0, 32'(chk_code0), 32'(last_code));
    check("idle_chk_code", 1, 32'(chk_code1), 32'(last_code));
    tick();

    // Start pulsed mid-sweep is ignored.
    tbl[15'h0401] = bitm(500);
    tbl[15'h0402] = bitm(501);
    do_start();
    send_code(15'h0401, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_code(15'h0402, 1'b1);
    wait_done();
    read_all();

    // Re-sweep clear, with a read in the start cycle returning the old word.
    tbl[15'h1234] = 1024'hFFFF_FFFF;
    tbl[15'h1235] = '0;
    do_start();
    send_code(15'h1234, 1'b1);
    wait_done();
    read_word(0);
    start   = 1'b1;
    rd_addr = 5'd0;
    rd_req  = 1'b1;
    rd_q0.push_back(exp_bmp[31:0]);
    rd_q1.push_back(exp_bmp[31:0]);
    tick();
    start  = 1'b0;
    rd_req = 1'b0;
    exp_bmp = '0;
    n_acc = 0;
    send_code(15'h1235, 1'b1);
    wait_done();
    read_all();

    // Counter sweep: blocked edges {3,7,900}.
    tbl[15'h0011] = bitm(3);
    tbl[15'h0012] = bitm(3);
    tbl[15'h0013] = bitm(7);
    tbl[15'h0014] = '0;
    tbl[15'h0015] = bitm(900);
    do_start();
    for (int i = 0; i < 5; i++) send_code(15'(15'h0011 + i), i == 4);
    wait_done();
    read_all();

    // Reset mid-sweep drops everything, no done.
    do_start();
    send_code(15'h0101, 1'b0);
    send_code(15'h0303, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_bmp = '0;
    n_acc = 0;
    @(negedge clk);
    check("post_rst_busy", 0, 32'(busy0), 32'd0);
    check("post_rst_busy", 1, 32'(busy1), 32'd0);
    check("post_rst_ready", 0, 32'(ready0), 32'd0);
    check("post_rst_ready", 1, 32'(ready1), 32'd0);
`ifdef PRM_SWEEP_CNT_EN
    check("post_rst_code_cnt", 0, 32'(cc0), 32'd0);
    check("post_rst_blk_cnt", 1, 32'(bc1), 32'd0);
`endif
    tick();
    read_all();

    // Randomized sweeps with idle gaps between codes.
    for (int s = 0; s < 8; s++) begin
      int n;
      n = $urandom_range(1, 8);
      do_start();
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_code(15'($urandom), i == n - 1);
      end
      wait_done();
      read_all();
    end

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
